// File: rtl/fwupd_bank_ctrl_if.sv
// Write/read handshake bundle between the update receiver, the URAM buffer and the
// flash-writer consumer; the controller takes the slave view.
interface fwupd_bank_ctrl_if #(
  parameter int unsigned ADDR_BITS = 7
);
  localparam int unsigned AW = ADDR_BITS + 1;

  logic          wr_valid_i;
  logic          wr_ready_o;
  logic          flush_i;
  logic          uram_we_o;
  logic [AW-1:0] uram_waddr_o;
  logic          rd_valid_o;
  logic          rd_bank_o;
  logic [AW-1:0] rd_len_o;
  logic          rd_done_i;
  logic          overflow_o;

  modport slave (
    input  wr_valid_i,
    input  flush_i,
    input  rd_done_i,
    output wr_ready_o,
    output uram_we_o,
    output uram_waddr_o,
    output rd_valid_o,
    output rd_bank_o,
    output rd_len_o,
    output overflow_o
  );

  modport master (
    output wr_valid_i,
    output flush_i,
    output rd_done_i,
    input  wr_ready_o,
    input  uram_we_o,
    input  uram_waddr_o,
    input  rd_valid_o,
    input  rd_bank_o,
    input  rd_len_o,
    input  overflow_o
  );
endinterface

// File: rtl/fwupd_bank_ctrl.sv
// Ping-pong bank controller for the firmware-update URAM buffer: fills banks from the
// word stream, closes them on fill or flush, and hands closed banks out in order.
module fwupd_bank_ctrl #(
  parameter int unsigned ADDR_BITS = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fwupd_bank_ctrl_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned LEN_W = ADDR_BITS + 1;

  logic [1:0]              full_q,  full_d;
  logic [1:0][LEN_W-1:0]   len_q,   len_d;
  logic                    wbank_q, wbank_d;
  logic [ADDR_BITS-1:0]    woff_q,  woff_d;
  logic                    rbank_q, rbank_d;
  logic                    we_q,    we_d;
  logic [LEN_W-1:0]        waddr_q, waddr_d;
  logic                    ovf_q,   ovf_d;

  logic             wr_ready_c;
  logic             accept_c;
  logic             fill_c;
  logic             flush_c;
  logic             close_c;
  logic             release_c;
  logic [LEN_W-1:0] close_len_c;

  // Write side decode: every term comes from registers or the current request only.
  always_comb begin
    wr_ready_c  = ~full_q[wbank_q];
    accept_c    = bus.wr_valid_i & wr_ready_c;
    fill_c      = accept_c & (&woff_q);
    flush_c     = bus.flush_i & wr_ready_c & (accept_c | (woff_q != '0));
    close_c     = fill_c | flush_c;
    // A fill lands on woff=DEPTH-1, so woff+accept also yields DEPTH there.
    close_len_c = LEN_W'(woff_q) + LEN_W'(accept_c);
    release_c   = bus.rd_done_i & full_q[rbank_q];
  end

  // Next-state: a close and a release always target different banks.
  always_comb begin
    full_d  = full_q;
    len_d   = len_q;
    wbank_d = wbank_q;
    woff_d  = woff_q;
    rbank_d = rbank_q;
    we_d    = accept_c;
    waddr_d = waddr_q;
    ovf_d   = ovf_q | (bus.wr_valid_i & ~wr_ready_c);

    if (accept_c) begin
      waddr_d = {wbank_q, woff_q};
      woff_d  = woff_q + ADDR_BITS'(1);
    end

    if (close_c) begin
      full_d[wbank_q] = 1'b1;
      len_d[wbank_q]  = close_len_c;
      wbank_d         = ~wbank_q;
      woff_d          = '0;
    end

    if (release_c) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q  <= '0;
      len_q   <= '0;
      wbank_q <= 1'b0;
      woff_q  <= '0;
      rbank_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      len_q   <= len_d;
      wbank_q <= wbank_d;
      woff_q  <= woff_d;
      rbank_q <= rbank_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.wr_ready_o   = wr_ready_c;
  assign bus.uram_we_o    = we_q;
  assign bus.uram_waddr_o = waddr_q;
  assign bus.rd_valid_o   = full_q[rbank_q];
  assign bus.rd_bank_o    = rbank_q;
  assign bus.rd_len_o     = len_q[rbank_q];
  assign bus.overflow_o   = ovf_q;

  // Structural invariants: no empty close, lengths bounded by the bank depth.
  a_no_empty_close: assert property (@(posedge clk_i) disable iff (rst_i)
    close_c |-> (close_len_c != '0));
  a_len_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    close_c |-> (close_len_c <= LEN_W'(DEPTH)));
  a_overflow_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
    ovf_q |=> ovf_q);

endmodule

// File: tb/tb_fwupd_bank_ctrl.sv
// Self-checking bench for fwupd_bank_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based bank model.
module tb_fwupd_bank_ctrl;

  localparam int unsigned AB    = 7;
  localparam int unsigned DEPTH = 2 ** AB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fwupd_bank_ctrl_if #(.ADDR_BITS(AB)) bus ();

  fwupd_bank_ctrl #(.ADDR_BITS(AB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic fl, input logic rd);
    bus.wr_valid_i = wv;
    bus.flush_i    = fl;
    bus.rd_done_i  = rd;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vector: inputs for one cycle, outputs expected after that edge.
  typedef struct {
    logic       wv, fl, rd;
    logic       we;
    logic [7:0] addr;
    logic       ready, rv, rb;
    logic [7:0] rl;
    logic       ovf;
  } vec_t;

  function automatic vec_t mk(int wv, int fl, int rd, int we, int addr, int ready,
                              int rv, int rb, int rl, int ovf);
    vec_t v;
    v.wv = 1'(wv);  v.fl = 1'(fl);  v.rd = 1'(rd);
    v.we = 1'(we);  v.addr = 8'(addr);  v.ready = 1'(ready);
    v.rv = 1'(rv);  v.rb = 1'(rb);  v.rl = 8'(rl);  v.ovf = 1'(ovf);
    return v;
  endfunction

  // Reference model: closed banks are a FIFO of {bank,len}; writing stalls when two wait.
  typedef struct {
    int bank;
    int len;
  } closed_t;

  closed_t mq[$];
  int      m_bank, m_cnt, m_addr;
  bit      m_we, m_ovf;

  task automatic m_reset();
    mq.delete();
    m_bank = 0; m_cnt = 0; m_addr = 0; m_we = 0; m_ovf = 0;
  endtask

  task automatic m_step(input bit wv, input bit fl, input bit rd);
    bit      ready, acc, pop;
    int      n;
    closed_t c;
    ready = (mq.size() < 2);
    acc   = wv && ready;
    pop   = rd && (mq.size() > 0);
    if (wv && !ready) m_ovf = 1;
    m_we = acc;
    if (acc) m_addr = m_bank * DEPTH + m_cnt;
    n = m_cnt + (acc ? 1 : 0);
    if (n == DEPTH || (fl && ready && n > 0)) begin
      c.bank = m_bank;
      c.len  = n;
      mq.push_back(c);
      m_bank = 1 - m_bank;
      m_cnt  = 0;
    end else begin
      m_cnt = n;
    end
    if (pop) void'(mq.pop_front());
  endtask

  task automatic check_model(input int cyc);
    chk($sformatf("rnd%0d_ready", cyc), 32'(bus.wr_ready_o), 32'(mq.size() < 2));
    chk($sformatf("rnd%0d_we", cyc),    32'(bus.uram_we_o),  32'(m_we));
    chk($sformatf("rnd%0d_addr", cyc),  32'(bus.uram_waddr_o), 32'(m_addr));
    chk($sformatf("rnd%0d_ovf", cyc),   32'(bus.overflow_o), 32'(m_ovf));
    chk($sformatf("rnd%0d_rv", cyc),    32'(bus.rd_valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk($sformatf("rnd%0d_rb", cyc), 32'(bus.rd_bank_o), 32'(mq[0].bank));
      chk($sformatf("rnd%0d_rl", cyc), 32'(bus.rd_len_o),  32'(mq[0].len));
    end
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = mk(1,0,0, 1,8'h00, 1, 0,0,0,   0);
    tbl[1]  = mk(1,0,0, 1,8'h01, 1, 0,0,0,   0);
    tbl[2]  = mk(1,0,0, 1,8'h02, 1, 0,0,0,   0);
    tbl[3]  = mk(1,0,0, 1,8'h03, 1, 0,0,0,   0);
    tbl[4]  = mk(1,0,0, 1,8'h04, 1, 0,0,0,   0);
    tbl[5]  = mk(0,1,0, 0,8'h04, 1, 1,0,5,   0);
    tbl[6]  = mk(0,1,0, 0,8'h04, 1, 1,0,5,   0);
    tbl[7]  = mk(1,0,0, 1,8'h80, 1, 1,0,5,   0);
    tbl[8]  = mk(1,1,0, 1,8'h81, 0, 1,0,5,   0);
    tbl[9]  = mk(1,0,0, 0,8'h81, 0, 1,0,5,   1);
    tbl[10] = mk(0,0,1, 0,8'h81, 1, 1,1,2,   1);
    tbl[11] = mk(0,0,1, 0,8'h81, 1, 0,0,0,   1);
    tbl[12] = mk(0,0,1, 0,8'h81, 1, 0,0,0,   1);
    tbl[13] = mk(1,0,0, 1,8'h00, 1, 0,0,0,   1);

    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_we",    32'(bus.uram_we_o),    32'd0);
    chk("rst_addr",  32'(bus.uram_waddr_o), 32'd0);
    chk("rst_ready", 32'(bus.wr_ready_o),   32'd1);
    chk("rst_rv",    32'(bus.rd_valid_o),   32'd0);
    chk("rst_rb",    32'(bus.rd_bank_o),    32'd0);
    chk("rst_rl",    32'(bus.rd_len_o),     32'd0);
    chk("rst_ovf",   32'(bus.overflow_o),   32'd0);
    rst = 1'b0;

    // Directed table: short fill, flush, double flush, both-full stall, release, idle done.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].wv, tbl[i].fl, tbl[i].rd);
      @(negedge clk);
      chk($sformatf("tbl%0d_we", i),    32'(bus.uram_we_o),    32'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i),  32'(bus.uram_waddr_o), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.wr_ready_o),   32'(tbl[i].ready));
      chk($sformatf("tbl%0d_rv", i),    32'(bus.rd_valid_o),   32'(tbl[i].rv));
      chk($sformatf("tbl%0d_rb", i),    32'(bus.rd_bank_o),    32'(tbl[i].rb));
      if (tbl[i].rv) chk($sformatf("tbl%0d_rl", i), 32'(bus.rd_len_o), 32'(tbl[i].rl));
      chk($sformatf("tbl%0d_ovf", i),   32'(bus.overflow_o),   32'(tbl[i].ovf));
    end

    // Full-bank stream: 128 back-to-back words.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("str%0d_we", i),   32'(bus.uram_we_o),    32'd1);
      chk($sformatf("str%0d_addr", i), 32'(bus.uram_waddr_o), 32'(i));
      if (i < DEPTH - 1) chk($sformatf("str%0d_rv", i), 32'(bus.rd_valid_o), 32'd0);
    end
    chk("str_close_rv", 32'(bus.rd_valid_o), 32'd1);
    chk("str_close_rb", 32'(bus.rd_bank_o),  32'd0);
    chk("str_close_rl", 32'(bus.rd_len_o),   32'd128);
    @(negedge clk);
    chk("str_next_addr", 32'(bus.uram_waddr_o), 32'h80);
    chk("str_next_we",   32'(bus.uram_we_o),    32'd1);

    // Both banks full, overflow, release restarts bank 0.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    repeat (2 * DEPTH) @(negedge clk);
    chk("ovf_last_addr", 32'(bus.uram_waddr_o), 32'hFF);
    chk("ovf_ready0",    32'(bus.wr_ready_o),   32'd0);
    chk("ovf_pre",       32'(bus.overflow_o),   32'd0);
    @(negedge clk);
    chk("ovf_no_we",     32'(bus.uram_we_o),    32'd0);
    chk("ovf_set",       32'(bus.overflow_o),   32'd1);
    drive(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovf_rel_rb",    32'(bus.rd_bank_o),    32'd1);
    chk("ovf_rel_rl",    32'(bus.rd_len_o),     32'd128);
    chk("ovf_rel_ready", 32'(bus.wr_ready_o),   32'd1);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_restart_we",   32'(bus.uram_we_o),    32'd1);
    chk("ovf_restart_addr", 32'(bus.uram_waddr_o), 32'h00);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_sticky", 32'(bus.overflow_o), 32'd1);

    // Flush coinciding with the filling word: one close of 128.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    repeat (DEPTH - 1) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("ff_addr",  32'(bus.uram_waddr_o), 32'h7F);
    chk("ff_rv",    32'(bus.rd_valid_o),   32'd1);
    chk("ff_rb",    32'(bus.rd_bank_o),    32'd0);
    chk("ff_rl",    32'(bus.rd_len_o),     32'd128);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ff_ready", 32'(bus.wr_ready_o),   32'd1);
    drive(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ff_single_close", 32'(bus.rd_valid_o), 32'd0);
    drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset with bank 0 closed and bank 1 at woff=40.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    repeat (DEPTH + 40) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    chk("ar_pre_rv", 32'(bus.rd_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_we",    32'(bus.uram_we_o),    32'd0);
    chk("ar_addr",  32'(bus.uram_waddr_o), 32'd0);
    chk("ar_ready", 32'(bus.wr_ready_o),   32'd1);
    chk("ar_rv",    32'(bus.rd_valid_o),   32'd0);
    chk("ar_rb",    32'(bus.rd_bank_o),    32'd0);
    chk("ar_rl",    32'(bus.rd_len_o),     32'd0);
    chk("ar_ovf",   32'(bus.overflow_o),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ar_first_we",   32'(bus.uram_we_o),    32'd1);
    chk("ar_first_addr", 32'(bus.uram_waddr_o), 32'h00);
    drive(1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model, alternating slow and fast consumers.
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      bit wv, fl, rd;
      int rdp;
      check_model(c);
      rdp = ((c / 500) % 2 == 1) ? 35 : 6;
      wv  = ($urandom_range(0, 99) < 70);
      fl  = ($urandom_range(0, 99) < 6);
      rd  = ($urandom_range(0, 99) < rdp);
      drive(wv, fl, rd);
      m_step(wv, fl, rd);
      @(negedge clk);
    end
    check_model(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
